// File: rtl/out_ch_if.sv
// ---------------------------------------------------------------------------
// out_ch_if : request/grant bundle between the input ports of a router and
// one output-channel controller.
//
//   master : input-port side. Drives req/req_vch/send_in/ityp and the
//            downstream credit_in. Sees grt/ilck/irdy/ovalid/ovch/cerr.
//   slave  : out_ch_ctrl side (the granting side).
//
//   req        [NIN]        input i wants this output
//   req_vch    [NIN*VCHW]   output VC wanted by input i (slice i*VCHW +: VCHW)
//   send_in    [NIN]        input i moves a flit this cycle
//   ityp       [NIN*2]      flit type of input i: 00 body 01 head 10 tail 11 headtail
//   credit_in  [NVCH]       credit return pulse from downstream, per VC
//   grt        [NIN]        one-hot grant, held for a whole packet
//   ilck       [NVCH]       VC locked by the packet in flight
//   irdy       [NVCH]       VC has at least one downstream credit
//   ovalid/ovch             flit forwarded downstream and its VC
//   cerr                    sticky credit error
// ---------------------------------------------------------------------------
interface out_ch_if #(
  parameter int NIN  = 5,
  parameter int NVCH = 2,
  parameter int VCHW = 1
);
  logic [NIN-1:0]      req;
  logic [NIN*VCHW-1:0] req_vch;
  logic [NIN-1:0]      send_in;
  logic [NIN*2-1:0]    ityp;
  logic [NVCH-1:0]     credit_in;
  logic [NIN-1:0]      grt;
  logic [NVCH-1:0]     ilck;
  logic [NVCH-1:0]     irdy;
  logic                ovalid;
  logic [VCHW-1:0]     ovch;
  logic                cerr;

  modport master (
    output req, req_vch, send_in, ityp, credit_in,
    input  grt, ilck, irdy, ovalid, ovch, cerr
  );

  modport slave (
    input  req, req_vch, send_in, ityp, credit_in,
    output grt, ilck, irdy, ovalid, ovch, cerr
  );
endinterface

// File: rtl/out_ch_ctrl.sv
// ---------------------------------------------------------------------------
// out_ch_ctrl : output-channel controller for one router output port.
//
// Round-robin arbitration over NIN input ports; the winner keeps the grant
// until its tail (or headtail) flit is forwarded. Each output VC has a credit
// counter tracking free downstream buffer slots; a flit only forwards when
// its VC has a credit.
//
// Ports:
//   clk   clock, rising edge
//   rst_  asynchronous active-low reset
//   ch    out_ch_if.slave (request/grant/credit bundle, see out_ch_if.sv)
//
// Optional build macro:
//   OUT_CH_CREDIT_CHECK_EN  builds the sticky credit-error detector behind
//                           ch.cerr (credit overflow / send without credit).
//                           Undefined: ch.cerr is tied to 0.
// ---------------------------------------------------------------------------

// Per-VC downstream credit counter. Starts full, decrements when a flit is
// forwarded on this VC, increments on a credit return, saturates at CRED.
module out_ch_cred #(
  parameter int CRED = 4
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] cnt
);
  localparam logic [3:0] CMAX = 4'(CRED);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      cnt <= CMAX;
    else if (inc && !dec && cnt != CMAX)
      cnt <= cnt + 4'd1;
    else if (dec && !inc)
      cnt <= cnt - 4'd1;  // dec only happens with cnt != 0 (ovalid gated by irdy)
  end
endmodule

module out_ch_ctrl #(
  parameter int NIN  = 5,
  parameter int NVCH = 2,
  parameter int VCHW = 1,
  parameter int CRED = 4
) (
  input  logic clk,
  input  logic rst_,
  out_ch_if.slave ch
);
  localparam int PW = (NIN > 1) ? $clog2(NIN) : 1;
  localparam logic [NIN-1:0] ONE = NIN'(1);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t                     state;
  logic [NIN-1:0]             grt_q;
  logic [NVCH-1:0]            ilck_q;
  logic [VCHW-1:0]            gvch;    // VC of the granted packet
  logic [PW-1:0]              gidx;    // index of the granted input
  logic [PW-1:0]              rr;      // round-robin start point

  logic [NIN-1:0][VCHW-1:0]   rvch;
  logic [NIN-1:0][1:0]        typ;
  logic [NIN-1:0]             elig;
  logic [NVCH-1:0][3:0]       cnt;
  logic [NVCH-1:0]            irdy_w;
  logic [NVCH-1:0]            dec;
  logic                       ovalid_w;
  logic                       is_tail;
  logic                       found;
  logic [PW-1:0]              pick;

  assign rvch = ch.req_vch;
  assign typ  = ch.ityp;

  // ---- credit counters, one per output VC --------------------------------
  for (genvar v = 0; v < NVCH; v++) begin : g_vc
    assign dec[v]    = ovalid_w && (gvch == VCHW'(v));
    assign irdy_w[v] = (cnt[v] != 4'd0);

    out_ch_cred #(.CRED(CRED)) u_cred (
      .clk  (clk),
      .rst_ (rst_),
      .inc  (ch.credit_in[v]),
      .dec  (dec[v]),
      .cnt  (cnt[v])
    );
  end

  // ---- eligibility: requester's VC must be free and have a credit --------
  for (genvar i = 0; i < NIN; i++) begin : g_in
    assign elig[i] = ch.req[i] && !ilck_q[rvch[i]] && irdy_w[rvch[i]];
  end

  // First eligible index at or after rr, wrapping modulo NIN. NIN need not
  // be a power of two, so wrap by subtraction rather than truncation.
  always_comb begin
    int j;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < NIN; k++) begin
      j = int'(rr) + k;
      if (j >= NIN) j = j - NIN;
      if (!found && elig[j]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
  end

  // ---- datapath handshake ------------------------------------------------
  // Sends from non-granted inputs are ignored: only send_in[gidx] counts.
  assign ovalid_w = (state == BUSY) && ch.send_in[gidx] && irdy_w[gvch];
  assign is_tail  = (typ[gidx] == 2'b10) || (typ[gidx] == 2'b11);

  // ---- arbitration FSM ---------------------------------------------------
  // Grant is registered, so it appears one cycle after an eligible request,
  // and a fresh grant cannot follow a tail in back-to-back cycles: the cycle
  // after the tail is spent in IDLE picking the next winner.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= IDLE;
      grt_q  <= '0;
      ilck_q <= '0;
      gvch   <= '0;
      gidx   <= '0;
      rr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state             <= BUSY;
            grt_q             <= ONE << pick;
            ilck_q[rvch[pick]] <= 1'b1;
            gvch              <= rvch[pick];
            gidx              <= pick;
            rr                <= (pick == PW'(NIN-1)) ? '0 : pick + PW'(1);
          end
        end
        BUSY: begin
          // Dropping req mid-packet does not release; only the tail does.
          if (ovalid_w && is_tail) begin
            state        <= IDLE;
            grt_q        <= '0;
            ilck_q[gvch] <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ch.grt    = grt_q;
  assign ch.ilck   = ilck_q;
  assign ch.irdy   = irdy_w;
  assign ch.ovalid = ovalid_w;
  assign ch.ovch   = gvch;

  // ---- optional sticky credit error --------------------------------------
`ifdef OUT_CH_CREDIT_CHECK_EN
  logic            cerr_q;
  logic [NVCH-1:0] full;
  logic            ovf_any;
  logic            no_cred;

  for (genvar v = 0; v < NVCH; v++) begin : g_full
    assign full[v] = (cnt[v] == 4'(CRED));
  end

  // Overflow: a credit arrives for a VC that already holds all CRED credits.
  assign ovf_any = |(ch.credit_in & full);
  // Granted input tries to send while its VC has no credit.
  assign no_cred = (state == BUSY) && ch.send_in[gidx] && (cnt[gvch] == 4'd0);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      cerr_q <= 1'b0;
    else if (ovf_any || no_cred)
      cerr_q <= 1'b1;
  end

  assign ch.cerr = cerr_q;
`else
  assign ch.cerr = 1'b0;
`endif

endmodule

// File: tb/tb_out_ch_ctrl.sv
// Bench for out_ch_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model (packet-level grant, integer
// credit counts).
module tb_out_ch_ctrl;
  localparam int NIN  = 5;
  localparam int NVCH = 2;
  localparam int VCHW = 1;
  localparam int CRED = 4;
`ifdef OUT_CH_CREDIT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk;
  logic rst_;
  int total = 0;
  int bad   = 0;

  out_ch_if #(.NIN(NIN), .NVCH(NVCH), .VCHW(VCHW)) ch ();

  out_ch_ctrl #(.NIN(NIN), .NVCH(NVCH), .VCHW(VCHW), .CRED(CRED)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .ch   (ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int mcnt[NVCH] = '{default: CRED};
  bit mbusy = 1'b0;
  int mg    = 0;
  int mvch  = 0;
  int mrr   = 0;
  bit mcerr = 1'b0;

  function automatic int vch_of(int i);
    return int'(ch.req_vch[i*VCHW +: VCHW]);
  endfunction

  function automatic bit m_ovalid();
    return mbusy && ch.send_in[mg] && (mcnt[mvch] > 0);
  endfunction

  // Only one packet is ever in flight, so in IDLE no VC is locked and the
  // only eligibility condition left is a credit on the requested VC.
  function automatic int m_pick();
    for (int k = 0; k < NIN; k++) begin
      int i;
      i = (mrr + k) % NIN;
      if (ch.req[i] && mcnt[vch_of(i)] > 0) return i;
    end
    return -1;
  endfunction

  function automatic int m_next_cnt(int v);
    bit d, c;
    d = m_ovalid() && (mvch == v);
    c = ch.credit_in[v];
    if (c && !d) return (mcnt[v] < CRED) ? mcnt[v] + 1 : CRED;
    if (d && !c) return mcnt[v] - 1;
    return mcnt[v];
  endfunction

  function automatic logic [NIN-1:0] m_grt();
    logic [NIN-1:0] r;
    r = '0;
    if (mbusy) r[mg] = 1'b1;
    return r;
  endfunction

  function automatic logic [NVCH-1:0] m_ilck();
    logic [NVCH-1:0] r;
    r = '0;
    if (mbusy) r[mvch] = 1'b1;
    return r;
  endfunction

  function automatic logic [NVCH-1:0] m_irdy();
    logic [NVCH-1:0] r;
    for (int v = 0; v < NVCH; v++) r[v] = (mcnt[v] > 0);
    return r;
  endfunction

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < NVCH; v++) mcnt[v] <= CRED;
      mbusy <= 1'b0; mg <= 0; mvch <= 0; mrr <= 0; mcerr <= 1'b0;
    end else begin
      for (int v = 0; v < NVCH; v++) begin
        mcnt[v] <= m_next_cnt(v);
        if (CHK_EN && ch.credit_in[v] && mcnt[v] == CRED) mcerr <= 1'b1;
      end
      if (CHK_EN && mbusy && ch.send_in[mg] && mcnt[mvch] == 0) mcerr <= 1'b1;
      if (!mbusy) begin
        if (m_pick() >= 0) begin
          mbusy <= 1'b1;
          mg    <= m_pick();
          mvch  <= vch_of(m_pick());
          mrr   <= (m_pick() + 1) % NIN;
        end
      end else if (m_ovalid() && ch.ityp[2*mg+1]) begin
        mbusy <= 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_inputs();
    ch.req = '0; ch.req_vch = '0; ch.send_in = '0; ch.ityp = '0; ch.credit_in = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_ = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_ = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    total++; if (ch.grt !== 5'b00000) begin bad++; $display("FAIL reset_grt: got %b want 00000", ch.grt); end
    total++; if (ch.ilck !== 2'b00) begin bad++; $display("FAIL reset_ilck: got %b want 00", ch.ilck); end
    total++; if (ch.irdy !== 2'b11) begin bad++; $display("FAIL reset_irdy: got %b want 11", ch.irdy); end
    total++; if (ch.ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid: got %b want 0", ch.ovalid); end
    total++; if (ch.ovch !== 1'b0) begin bad++; $display("FAIL reset_ovch: got %b want 0", ch.ovch); end
    total++; if (ch.cerr !== 1'b0) begin bad++; $display("FAIL reset_cerr: got %b want 0", ch.cerr); end
    rst_ = 1'b1;
  endtask

  task automatic test_single_grant();
    reset_dut();
    ch.req[2] = 1'b1;
    ch.req_vch[2*VCHW +: VCHW] = VCHW'(1);
    @(negedge clk);
    total++; if (ch.grt !== 5'b00100) begin bad++; $display("FAIL single_grt: got %b want 00100", ch.grt); end
    total++; if (ch.ilck !== 2'b10) begin bad++; $display("FAIL single_ilck: got %b want 10", ch.ilck); end
    total++; if (ch.irdy !== 2'b11) begin bad++; $display("FAIL single_irdy: got %b want 11", ch.irdy); end
    ch.req = '0;
    ch.send_in[2] = 1'b1;
    ch.ityp[4 +: 2] = 2'b11;
    #1;
    total++; if (ch.ovalid !== 1'b1) begin bad++; $display("FAIL single_ovalid: got %b want 1", ch.ovalid); end
    total++; if (ch.ovch !== 1'b1) begin bad++; $display("FAIL single_ovch: got %b want 1", ch.ovch); end
    @(negedge clk);
    ch.send_in = '0;
    #1;
    total++; if (ch.grt !== 5'b00000) begin bad++; $display("FAIL single_release: got %b want 00000", ch.grt); end
    total++; if (ch.ilck !== 2'b00) begin bad++; $display("FAIL single_unlock: got %b want 00", ch.ilck); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    ch.req = 5'b01001;  // inputs 0 and 3, both VC0
    @(negedge clk);
    total++; if (ch.grt !== 5'b00001) begin bad++; $display("FAIL rr_first: got %b want 00001", ch.grt); end
    ch.req[0] = 1'b0;
    ch.send_in[0] = 1'b1;
    ch.ityp[0 +: 2] = 2'b11;
    @(negedge clk);
    // Cycle after the tail: back in IDLE, no grant yet (bubble).
    ch.send_in = '0;
    ch.req = 5'b01001;
    #1;
    total++; if (ch.grt !== 5'b00000) begin bad++; $display("FAIL rr_bubble: got %b want 00000", ch.grt); end
    @(negedge clk);
    total++; if (ch.grt !== 5'b01000) begin bad++; $display("FAIL rr_second: got %b want 01000", ch.grt); end
    // Dropping req does not release the grant.
    ch.req = '0;
    @(negedge clk);
    total++; if (ch.grt !== 5'b01000) begin bad++; $display("FAIL rr_hold: got %b want 01000", ch.grt); end
    // A non-granted input sending is ignored.
    ch.send_in[1] = 1'b1;
    ch.ityp[2 +: 2] = 2'b11;
    #1;
    total++; if (ch.ovalid !== 1'b0) begin bad++; $display("FAIL rr_ignore: got %b want 0", ch.ovalid); end
    clear_inputs();
  endtask

  task automatic test_packet_credits();
    logic [1:0] ty [4] = '{2'b01, 2'b00, 2'b00, 2'b10};
    reset_dut();
    ch.req[1] = 1'b1;
    @(negedge clk);
    ch.req = '0;
    for (int k = 0; k < 4; k++) begin
      ch.send_in[1] = 1'b1;
      ch.ityp[2 +: 2] = ty[k];
      #1;
      total++; if (ch.ovalid !== 1'b1) begin bad++; $display("FAIL pkt_ovalid%0d: got %b want 1", k, ch.ovalid); end
      total++; if (dut.cnt[0] !== 4'(CRED - k)) begin bad++; $display("FAIL pkt_cnt%0d: got %0d want %0d", k, dut.cnt[0], CRED - k); end
      total++; if (ch.irdy[0] !== 1'b1) begin bad++; $display("FAIL pkt_irdy%0d: got %b want 1", k, ch.irdy[0]); end
      @(negedge clk);
    end
    ch.send_in = '0;
    #1;
    total++; if (ch.ilck[0] !== 1'b0) begin bad++; $display("FAIL pkt_unlock: got %b want 0", ch.ilck[0]); end
    total++; if (ch.irdy[0] !== 1'b0) begin bad++; $display("FAIL pkt_empty: got %b want 0", ch.irdy[0]); end
  endtask

  task automatic test_credit_exhaust();
    reset_dut();
    ch.req[4] = 1'b1;
    @(negedge clk);
    ch.req = '0;
    total++; if (ch.grt !== 5'b10000) begin bad++; $display("FAIL exh_grt: got %b want 10000", ch.grt); end
    for (int k = 0; k < 4; k++) begin
      ch.send_in[4] = 1'b1;
      ch.ityp[8 +: 2] = (k == 0) ? 2'b01 : 2'b00;
      #1;
      total++; if (ch.ovalid !== 1'b1) begin bad++; $display("FAIL exh_ovalid%0d: got %b want 1", k, ch.ovalid); end
      @(negedge clk);
    end
    ch.ityp[8 +: 2] = 2'b10;
    #1;
    total++; if (ch.ovalid !== 1'b0) begin bad++; $display("FAIL exh_stall: got %b want 0", ch.ovalid); end
    total++; if (ch.irdy[0] !== 1'b0) begin bad++; $display("FAIL exh_irdy0: got %b want 0", ch.irdy[0]); end
    @(negedge clk);
    ch.credit_in[0] = 1'b1;
    #1;
    total++; if (ch.ovalid !== 1'b0) begin bad++; $display("FAIL exh_stall2: got %b want 0", ch.ovalid); end
    @(negedge clk);
    ch.credit_in = '0;
    #1;
    total++; if (ch.irdy[0] !== 1'b1) begin bad++; $display("FAIL exh_irdy1: got %b want 1", ch.irdy[0]); end
    total++; if (ch.ovalid !== 1'b1) begin bad++; $display("FAIL exh_resume: got %b want 1", ch.ovalid); end
    @(negedge clk);
    ch.send_in = '0;
    #1;
    total++; if (ch.grt !== 5'b00000) begin bad++; $display("FAIL exh_release: got %b want 00000", ch.grt); end
    total++; if (ch.cerr !== CHK_EN) begin bad++; $display("FAIL exh_cerr: got %b want %b", ch.cerr, CHK_EN); end
  endtask

  task automatic test_credit_sim();
    reset_dut();
    ch.req[0] = 1'b1;
    ch.req_vch[0 +: VCHW] = VCHW'(1);
    @(negedge clk);
    ch.req = '0;
    ch.send_in[0] = 1'b1;
    ch.ityp[0 +: 2] = 2'b01;
    @(negedge clk);
    ch.ityp[0 +: 2] = 2'b00;
    ch.credit_in[1] = 1'b1;
    #1;
    total++; if (ch.ovalid !== 1'b1) begin bad++; $display("FAIL sim_ovalid: got %b want 1", ch.ovalid); end
    @(negedge clk);
    ch.credit_in = '0;
    ch.ityp[0 +: 2] = 2'b10;
    #1;
    total++; if (dut.cnt[1] !== 4'd3) begin bad++; $display("FAIL sim_cnt: got %0d want 3", dut.cnt[1]); end
    @(negedge clk);
    ch.send_in = '0;
    ch.credit_in[1] = 1'b1;
    #1;
    total++; if (dut.cnt[1] !== 4'd2) begin bad++; $display("FAIL sim_cnt_tail: got %0d want 2", dut.cnt[1]); end
    @(negedge clk);
    total++; if (dut.cnt[1] !== 4'd3) begin bad++; $display("FAIL sim_cnt_ret1: got %0d want 3", dut.cnt[1]); end
    @(negedge clk);
    total++; if (dut.cnt[1] !== 4'd4) begin bad++; $display("FAIL sim_cnt_full: got %0d want 4", dut.cnt[1]); end
    total++; if (ch.cerr !== 1'b0) begin bad++; $display("FAIL sim_cerr_pre: got %b want 0", ch.cerr); end
    @(negedge clk);
    ch.credit_in = '0;
    #1;
    total++; if (dut.cnt[1] !== 4'd4) begin bad++; $display("FAIL sim_cnt_sat: got %0d want 4", dut.cnt[1]); end
    total++; if (ch.cerr !== CHK_EN) begin bad++; $display("FAIL sim_cerr_ovf: got %b want %b", ch.cerr, CHK_EN); end
  endtask

  task automatic test_reset_midpacket();
    reset_dut();
    ch.req[1] = 1'b1;
    @(negedge clk);
    ch.req = '0;
    ch.send_in[1] = 1'b1;
    ch.ityp[2 +: 2] = 2'b01;
    @(negedge clk);
    ch.ityp[2 +: 2] = 2'b00;
    @(negedge clk);
    total++; if (dut.cnt[0] !== 4'd2) begin bad++; $display("FAIL mid_cnt_pre: got %0d want 2", dut.cnt[0]); end
    rst_ = 1'b0;
    #1;
    total++; if (ch.grt !== 5'b00000) begin bad++; $display("FAIL mid_grt: got %b want 00000", ch.grt); end
    total++; if (ch.ilck !== 2'b00) begin bad++; $display("FAIL mid_ilck: got %b want 00", ch.ilck); end
    total++; if (dut.cnt[0] !== 4'(CRED)) begin bad++; $display("FAIL mid_cnt: got %0d want %0d", dut.cnt[0], CRED); end
    total++; if (ch.ovalid !== 1'b0) begin bad++; $display("FAIL mid_ovalid: got %b want 0", ch.ovalid); end
    total++; if (ch.cerr !== 1'b0) begin bad++; $display("FAIL mid_cerr: got %b want 0", ch.cerr); end
    @(negedge clk);
    clear_inputs();
    rst_ = 1'b1;
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      ch.req       = NIN'($urandom);
      ch.req_vch   = (NIN*VCHW)'($urandom);
      ch.send_in   = NIN'($urandom);
      ch.ityp      = (2*NIN)'($urandom);
      ch.credit_in = ($urandom_range(0, 2) == 0) ? NVCH'($urandom) : '0;
      #1;
      total++; if (ch.grt !== m_grt()) begin bad++; $display("FAIL rnd_grt c=%0d: got %b want %b", c, ch.grt, m_grt()); end
      total++; if (ch.ilck !== m_ilck()) begin bad++; $display("FAIL rnd_ilck c=%0d: got %b want %b", c, ch.ilck, m_ilck()); end
      total++; if (ch.irdy !== m_irdy()) begin bad++; $display("FAIL rnd_irdy c=%0d: got %b want %b", c, ch.irdy, m_irdy()); end
      total++; if (ch.ovalid !== m_ovalid()) begin bad++; $display("FAIL rnd_ovalid c=%0d: got %b want %b", c, ch.ovalid, m_ovalid()); end
      if (m_ovalid()) begin
        total++; if (ch.ovch !== VCHW'(mvch)) begin bad++; $display("FAIL rnd_ovch c=%0d: got %0d want %0d", c, ch.ovch, mvch); end
      end
      total++; if (ch.cerr !== mcerr) begin bad++; $display("FAIL rnd_cerr c=%0d: got %b want %b", c, ch.cerr, mcerr); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_packet_credits();
    test_credit_exhaust();
    test_credit_sim();
    test_reset_midpacket();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
